mem_stage_reg: RTL and testbench

Parametrised Execute-to-Memory pipeline register for the Y86-64 pipelined core, the successor to the fixed-width bubble-only E/M register. It latches Execute-stage results each cycle and also supports stall (hold), bubble (NOP injection) and synchronous reset. It flags illegal control combinations and keeps saturating stall and bubble performance counters. It sits between the execute stage and data memory and is driven by the pipeline control logic.

---
 rtl/mem_stage_reg.sv | 114 +++++++++++
 tb/tb_mem_stage_reg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  mem_stage_reg : Execute-to-Memory pipeline register with stall, bubble,
//                  control-error flag and saturating stall/bubble counters.
//  Revision      : 1.0
// ----------------------------------------------------------------------------
module mem_stage_reg #(
  parameter int                  WORD_W    = 64,
  parameter int                  ICODE_W   = 4,
  parameter int                  REG_W     = 4,
  parameter int                  STAT_W    = 3,
  parameter logic [ICODE_W-1:0]  NOP_ICODE = 1,
  parameter logic [REG_W-1:0]    RNONE     = '1,
  parameter logic [STAT_W-1:0]   SAOK      = 1,
  parameter int                  CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                M_stall,
  input  logic                M_bubble,
  input  logic                cnt_clr,
  input  logic [STAT_W-1:0]   e_stat,
  input  logic [ICODE_W-1:0]  e_icode,
  input  logic                e_cnd,
  input  logic [WORD_W-1:0]   e_valE,
  input  logic [WORD_W-1:0]   e_valA,
  input  logic [REG_W-1:0]    e_dstE,
  input  logic [REG_W-1:0]    e_dstM,
  output logic [STAT_W-1:0]   M_stat,
  output logic [ICODE_W-1:0]  M_icode,
  output logic                M_cnd,
  output logic [WORD_W-1:0]   M_valE,
  output logic [WORD_W-1:0]   M_valA,
  output logic [REG_W-1:0]    M_dstE,
  output logic [REG_W-1:0]    M_dstM,
  output logic                M_valid,
  output logic                ctl_err,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0]  r_stat;
  logic [ICODE_W-1:0] r_icode;
  logic               r_cnd;
  logic [WORD_W-1:0]  r_valE;
  logic [WORD_W-1:0]  r_valA;
  logic [REG_W-1:0]   r_dstE;
  logic [REG_W-1:0]   r_dstM;
  logic               r_valid;
  logic               r_ctl_err;
  logic [CNT_W-1:0]   r_bubble_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;

  // Bubble outranks stall, so a stall only matters when no bubble is present.
  logic w_load_nop;
  logic w_hold;
  assign w_load_nop = rst | M_bubble;
  assign w_hold     = M_stall & ~M_bubble;

  always_ff @(posedge clk) begin
    if (w_load_nop) begin
      r_stat  <= SAOK;
      r_icode <= NOP_ICODE;
      r_cnd   <= 1'b1;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_valid <= 1'b0;
    end else if (!w_hold) begin
      r_stat  <= e_stat;
      r_icode <= e_icode;
      r_cnd   <= e_cnd;
      r_valE  <= e_valE;
      r_valA  <= e_valA;
      r_dstE  <= e_dstE;
      r_dstM  <= e_dstM;
      r_valid <= 1'b1;
    end
  end

  // A clear in the same cycle as an increment leaves the counter at zero.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
      r_ctl_err    <= 1'b0;
    end else begin
      if (M_bubble && (r_bubble_cnt != c_CNT_MAX))
        r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
      if (w_hold && (r_stall_cnt != c_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      if (M_bubble && M_stall)
        r_ctl_err <= 1'b1;
    end
  end

  assign M_stat     = r_stat;
  assign M_icode    = r_icode;
  assign M_cnd      = r_cnd;
  assign M_valE     = r_valE;
  assign M_valA     = r_valA;
  assign M_dstE     = r_dstE;
  assign M_dstM     = r_dstM;
  assign M_valid    = r_valid;
  assign ctl_err    = r_ctl_err;
  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  tb_mem_stage_reg : directed self-checking bench for mem_stage_reg
//                     (counters built 4 bits wide to reach saturation quickly).
//  Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_mem_stage_reg;

  localparam int c_CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst, M_stall, M_bubble, cnt_clr;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  e_dstE, e_dstM;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic        M_valid, ctl_err;
  logic [c_CNT_W-1:0] bubble_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  mem_stage_reg #(.CNT_W(c_CNT_W)) dut (
    .clk(clk), .rst(rst), .M_stall(M_stall), .M_bubble(M_bubble), .cnt_clr(cnt_clr),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valid(M_valid), .ctl_err(ctl_err),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_icode"}, 64'(M_icode), 64'd1);
    chk({tag, "_stat"},  64'(M_stat),  64'd1);
    chk({tag, "_cnd"},   64'(M_cnd),   64'd1);
    chk({tag, "_valE"},  M_valE,       64'd0);
    chk({tag, "_valA"},  M_valA,       64'd0);
    chk({tag, "_dstE"},  64'(M_dstE),  64'hF);
    chk({tag, "_dstM"},  64'(M_dstM),  64'hF);
    chk({tag, "_valid"}, 64'(M_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; M_stall = 1'b0; M_bubble = 1'b0; cnt_clr = 1'b0;
    e_stat  = 3'($urandom);  e_icode = 4'($urandom); e_cnd = 1'($urandom);
    e_valE  = {$urandom, $urandom}; e_valA = {$urandom, $urandom};
    e_dstE  = 4'($urandom);  e_dstM = 4'($urandom);
    step(); step();
    chk_nop("reset");
    chk("reset_bcnt", 64'(bubble_cnt), 64'd0);
    chk("reset_scnt", 64'(stall_cnt),  64'd0);
    chk("reset_err",  64'(ctl_err),    64'd0);

    // Pass-through
    rst = 1'b0;
    e_valE = 64'h0123456789ABCDEF; e_valA = 64'hDEADBEEF00C0FFEE;
    e_icode = 4'd6; e_dstE = 4'd3; e_dstM = 4'd5; e_cnd = 1'b0; e_stat = 3'd2;
    step();
    chk("pass_valE",  M_valE,           64'h0123456789ABCDEF);
    chk("pass_valA",  M_valA,           64'hDEADBEEF00C0FFEE);
    chk("pass_icode", 64'(M_icode),     64'd6);
    chk("pass_dstE",  64'(M_dstE),      64'd3);
    chk("pass_dstM",  64'(M_dstM),      64'd5);
    chk("pass_cnd",   64'(M_cnd),       64'd0);
    chk("pass_stat",  64'(M_stat),      64'd2);
    chk("pass_valid", 64'(M_valid),     64'd1);

    // Stall for three edges while the execute stage moves on
    e_icode = 4'd5; step();
    chk("stall_pre_icode", 64'(M_icode), 64'd5);
    M_stall = 1'b1; e_icode = 4'd2; e_valE = 64'h1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_icode", 64'(M_icode), 64'd5);
      chk("stall_hold_valE",  M_valE,       64'h0123456789ABCDEF);
    end
    chk("stall_cnt3",  64'(stall_cnt),  64'd3);
    chk("stall_bcnt0", 64'(bubble_cnt), 64'd0);
    M_stall = 1'b0; step();
    chk("stall_rel_icode", 64'(M_icode), 64'd2);
    chk("stall_rel_valE",  M_valE,       64'h1111);
    chk("stall_rel_cnt",   64'(stall_cnt), 64'd3);

    // Simultaneous stall and bubble
    M_stall = 1'b1; M_bubble = 1'b1; step();
    chk_nop("both");
    chk("both_err",  64'(ctl_err),    64'd1);
    chk("both_bcnt", 64'(bubble_cnt), 64'd1);
    chk("both_scnt", 64'(stall_cnt),  64'd3);
    // Stall after the bubble holds the NOP image
    M_bubble = 1'b0; step();
    chk_nop("both_hold");
    chk("both_hold_scnt", 64'(stall_cnt), 64'd4);
    M_stall = 1'b0; step();
    chk("err_sticky", 64'(ctl_err), 64'd1);
    chk("err_sticky_valid", 64'(M_valid), 64'd1);
    cnt_clr = 1'b1; e_icode = 4'd9; step();
    chk("clr_err",   64'(ctl_err),    64'd0);
    chk("clr_bcnt",  64'(bubble_cnt), 64'd0);
    chk("clr_scnt",  64'(stall_cnt),  64'd0);
    chk("clr_icode", 64'(M_icode),    64'd9);
    chk("clr_valid", 64'(M_valid),    64'd1);
    cnt_clr = 1'b0;

    // Bubble saturation at 15
    M_bubble = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat_bcnt14", 64'(bubble_cnt), 64'd14);
    end
    chk("sat_bcnt", 64'(bubble_cnt), 64'd15);
    chk("sat_err",  64'(ctl_err),    64'd0);
    cnt_clr = 1'b1; step();
    chk("sat_clr_bcnt", 64'(bubble_cnt), 64'd0);
    cnt_clr = 1'b0; M_bubble = 1'b0;

    // Reset in the middle of a stall
    e_icode = 4'd7; step();
    chk("rst_pre_icode", 64'(M_icode), 64'd7);
    M_stall = 1'b1; step(); step();
    chk("rst_pre_scnt",  64'(stall_cnt), 64'd2);
    chk("rst_pre_hold",  64'(M_icode),   64'd7);
    rst = 1'b1; step();
    chk_nop("rst_mid");
    chk("rst_mid_scnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0; step();
    chk_nop("rst_after");
    chk("rst_after_scnt", 64'(stall_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
